// File: rtl/sigdelay.sv
// Programmable sample delay line built on a circular dual-port RAM.
// Each strobed sample is written at a wrapping pointer and replayed `offset` strobes later.
module sigdelay #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] offset,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic [ADDR_WIDTH-1:0] wr_addr
);

    localparam logic [ADDR_WIDTH-1:0] FILL_MAX = '1;

    typedef enum logic {
        FILLING,
        FULL
    } state_t;

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] fill;
    logic [ADDR_WIDTH-1:0] rd_addr;
    state_t                state;

    // Wrapping subtraction uses the pointer before this strobe's increment.
    assign rd_addr = wr_ptr - offset;
    assign wr_addr = wr_ptr;

    // Storage survives reset; only the sample strobed during reset is dropped.
    always_ff @(posedge clk) begin
        if (en && !rst) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            fill       <= '0;
            state      <= FILLING;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (en) begin
            wr_ptr <= wr_ptr + 1'b1;

            case (state)
                FILLING: begin
                    fill <= fill + 1'b1;
                    if (fill == FILL_MAX - 1'b1) begin
                        state <= FULL;
                    end
                end
                FULL: begin
                    fill <= fill;
                end
                default: begin
                    state <= FILLING;
                end
            endcase

            // Offset 0 bypasses the RAM; otherwise rd_addr never equals wr_ptr.
            if (fill >= offset) begin
                dout_valid <= 1'b1;
                dout       <= (offset == '0) ? din : mem[rd_addr];
            end else begin
                dout_valid <= 1'b0;
                dout       <= '0;
            end
        end else begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: doc/sigdelay.md
# sigdelay

Sample-delay line that writes an incoming sample stream into a circular dual-port RAM and reads it back a programmable number of samples later. It is the write-side counterpart of the ROM-based waveform generator: the generator reads stored samples at a counter address, while this block captures live samples (e.g. ADC/mic data) at a wrapping write pointer. Its read port replays each sample `offset` samples later, giving a variable delay for the signal-generation datapath.

## Interface

- `ADDR_WIDTH`, default 9: RAM address width. Depth is 2^ADDR_WIDTH samples.
- `DATA_WIDTH`, default 8: sample width.

- `clk`  in  1  Clock. All state changes on the rising edge.
- `rst`  in  1  Reset, synchronous and active-high.
- `en`  in  1  Sample strobe. High for one cycle per input sample.
- `offset`  in  ADDR_WIDTH  Delay in samples, 0 to 2^ADDR_WIDTH-1. Sampled every `en` cycle.
- `din`  in  DATA_WIDTH  Input sample, valid when `en`=1.
- `dout`  out  DATA_WIDTH  Delayed sample. Registered.
- `dout_valid`  out  1  High for one cycle when `dout` carries a real delayed sample.
- `wr_addr`  out  ADDR_WIDTH  Current write pointer, for debug and test.

## Operation

- **Storage:** internal RAM `mem[0 .. 2^ADDR_WIDTH-1]`, DATA_WIDTH wide. It has one write port and one synchronous read port, and is not cleared by reset.
- **Write pointer `wr_ptr`:**
  - On each `en` cycle: `mem[wr_ptr] <= din` and `wr_ptr <= wr_ptr + 1`, modulo 2^ADDR_WIDTH.
  - Wraps from 2^ADDR_WIDTH-1 to 0 silently.
  - `wr_addr` = `wr_ptr`.
- **Read address:** `rd_addr = wr_ptr - offset`, modulo 2^ADDR_WIDTH (ADDR_WIDTH-bit wrap subtraction). It is computed from the pointer value before that cycle's increment.
- **Offset 0:** bypass. `dout <= din` on the `en` cycle, with no RAM read. For offset ≥1, `rd_addr != wr_ptr`, so there is never a read/write collision on the same address.
- **Fill counter `fill`:**
  - Counts samples written since reset, saturating at 2^ADDR_WIDTH-1.
  - Two-state FSM derived from it: FILLING (`fill` < 2^ADDR_WIDTH-1) and FULL (saturated).
  - FULL is left only by `rst`.
- **Valid rule, on an `en` cycle:**
  - If the pre-increment `fill` ≥ `offset`, then `dout_valid <= 1` and `dout <=` RAM/bypass data.
  - Otherwise `dout_valid <= 0` and `dout <= 0`.
  - Net effect: output for input sample k (0-indexed since reset) equals input sample k-`offset`. It is valid iff k ≥ `offset`.
- **`en` = 0:** no write, `wr_ptr` and `fill` hold, `dout` holds its value, `dout_valid <= 0`.
- **Offset change mid-stream:** takes effect on the next `en` cycle. There is no flush. The valid rule is re-evaluated against the current `fill`, and old RAM contents are considered legitimate history.
- **Reset (any time, including mid-stream):** next edge sets `wr_ptr`=0, `fill`=0, `dout`=0, `dout_valid`=0. The `en` sample in a reset cycle is discarded.

## Timing

- **Latency:** `dout`/`dout_valid` update on the clock edge ending the `en` cycle. They are visible one cycle after `din` is presented.
- **Throughput:** one sample per cycle. `en` may be held high continuously.
- **Back-to-back `en`:** each cycle reads the location written `offset` strobes earlier. The RAM read is synchronous, with registered address-to-data, so the read must be issued in the same `en` cycle as the write.
- **Reset values:** `dout`=0, `dout_valid`=0, `wr_addr`=0.
- **Simultaneous `rst` and `en`:** reset wins.

## Test plan

- **Reset:** hold `rst` 2 cycles with `en`=1 and `din`=0xAA -> `dout`=0, `dout_valid`=0, `wr_addr`=0. Nothing written is observable afterwards.
- **Bypass:** `offset`=0, `en` continuous, `din`=0x10,0x11,0x12 -> `dout`=0x10,0x11,0x12 one cycle later each, with `dout_valid`=1 from the first sample.
- **Fixed delay:** `offset`=3, ramp `din`=0..9 continuous -> `dout_valid`=0 for samples 0-2. Samples 3..9 give `dout`=0,1,...,6.
- **Wrap and maximum delay:** `offset`=511, ramp `din`=k mod 256 for 1100 samples -> `wr_addr` wraps to 0 after 512 writes. Sample k≥511 gives `dout`=(k-511) mod 256, and `dout_valid` first rises at k=511.
- **Gapped `en`:** `offset`=2, `en` pulsed every 3rd cycle with `din`=5,6,7,8 -> outputs 5,6 on the 3rd and 4th strobes. `dout_valid` is high only one cycle per strobe, and `dout` holds between strobes.
- **Reset mid-stream / offset change:**
  - After 20 samples with `offset`=4, assert `rst` -> next `offset`=4 output is invalid until 4 new samples are written.
  - Separately, changing `offset` 4->1 mid-stream -> the next output equals the sample written one strobe earlier, with `dout_valid`=1.
